// File: rtl/pe_acc_pipe.sv
// Convolution PE: windowed signed dot product against a double-buffered
// weight file, channel accumulation in a psum buffer, and a rounded,
// saturated (optionally ReLU'd) 8-bit result behind a valid/ready handshake.
// Pipeline: S1 registers the masked products; S2 sums them with the base
// and commits either to the psum buffer or to the output register.
module pe_acc_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_DIM   = 6,
  parameter int ACC_WIDTH   = 24,
  parameter int PSUM_DEPTH  = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_cfg_wr,
  input  logic [$clog2(ARRAY_DIM+1)-1:0]              i_ksize,
  input  logic [SHIFT_WIDTH-1:0]                      i_shift,
  input  logic                                        i_relu,
  input  logic [DATA_WIDTH-1:0]                       i_bias,
  input  logic                                        i_wgt_wr_en,
  input  logic [$clog2(ARRAY_DIM)-1:0]                i_wgt_row,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0]             i_wgt_data,
  input  logic                                        i_wgt_swap,
  input  logic                                        i_in_valid,
  output logic                                        o_in_ready,
  input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0]   i_img,
  input  logic                                        i_first,
  input  logic                                        i_last,
  input  logic [$clog2(PSUM_DEPTH)-1:0]               i_addr,
  output logic                                        o_out_valid,
  input  logic                                        i_out_ready,
  output logic [DATA_WIDTH-1:0]                       o_result,
  output logic                                        o_busy
);

  localparam int KW     = $clog2(ARRAY_DIM+1);
  localparam int RW     = $clog2(ARRAY_DIM);
  localparam int AW     = $clog2(PSUM_DEPTH);
  localparam int NE     = ARRAY_DIM*ARRAY_DIM;
  localparam int PW     = 2*DATA_WIDTH;
  localparam int DOT_W  = PW + $clog2(NE);
  localparam int BASE_W = DATA_WIDTH + (1 << SHIFT_WIDTH) - 1;
  localparam int MAX_W  = (DOT_W > BASE_W) ? ((DOT_W > ACC_WIDTH) ? DOT_W : ACC_WIDTH)
                                           : ((BASE_W > ACC_WIDTH) ? BASE_W : ACC_WIDTH);
  // One guard bit so dot + base cannot wrap before saturation.
  localparam int SUM_W  = MAX_W + 1;
  localparam int RND_W  = ACC_WIDTH + 1;

  localparam logic [KW-1:0] K_MAX   = KW'(ARRAY_DIM);
  localparam logic [RW:0]   ROW_LIM = (RW+1)'(ARRAY_DIM);

  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [RND_W-1:0] RES_MAX = {{(RND_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] RES_MIN = {{(RND_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef logic signed [PW-1:0]         prod_t;

  elem_t                        wgt_shadow [ARRAY_DIM][ARRAY_DIM];
  elem_t                        wgt_active [ARRAY_DIM][ARRAY_DIM];
  logic [KW-1:0]                k_q;
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic                         relu_q;
  elem_t                        bias_q;

  logic                         s1_valid;
  logic                         s1_first;
  logic                         s1_last;
  logic [AW-1:0]                s1_addr;
  prod_t                        s1_prod  [NE];
  prod_t                        prod_nxt [NE];

  logic signed [ACC_WIDTH-1:0]  psum [PSUM_DEPTH];

  logic                         stall;
  logic signed [SUM_W-1:0]      dot;
  logic signed [SUM_W-1:0]      base;
  logic signed [SUM_W-1:0]      sum_raw;
  logic signed [ACC_WIDTH-1:0]  sum_sat;
  logic signed [RND_W-1:0]      rnd_add;
  logic signed [RND_W-1:0]      rnd_sum;
  logic signed [RND_W-1:0]      shifted;
  logic [DATA_WIDTH-1:0]        res_nxt;

  assign stall      = o_out_valid & ~i_out_ready;
  assign o_in_ready = ~stall;
  assign o_busy     = s1_valid | o_out_valid;

  // Configuration: only taken while the pipe is empty so in-flight beats see one setting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q     <= K_MAX;
      shift_q <= '0;
      relu_q  <= 1'b0;
      bias_q  <= '0;
    end else if (i_cfg_wr && !o_busy) begin
      k_q     <= (i_ksize == '0 || i_ksize > K_MAX) ? K_MAX : i_ksize;
      shift_q <= i_shift;
      relu_q  <= i_relu;
      bias_q  <= elem_t'(i_bias);
    end
  end

  // Weight banks: swap copies the pre-write shadow, a same-cycle write lands in shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < ARRAY_DIM; r++) begin
        for (int c = 0; c < ARRAY_DIM; c++) begin
          wgt_shadow[r][c] <= '0;
          wgt_active[r][c] <= '0;
        end
      end
    end else begin
      if (i_wgt_swap) begin
        for (int r = 0; r < ARRAY_DIM; r++) begin
          for (int c = 0; c < ARRAY_DIM; c++) begin
            wgt_active[r][c] <= wgt_shadow[r][c];
          end
        end
      end
      if (i_wgt_wr_en && ({1'b0, i_wgt_row} < ROW_LIM)) begin
        for (int c = 0; c < ARRAY_DIM; c++) begin
          wgt_shadow[i_wgt_row][c] <= elem_t'(i_wgt_data[c*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  // Masked element products; rows/columns outside the kernel contribute zero.
  always_comb begin
    for (int r = 0; r < ARRAY_DIM; r++) begin
      for (int c = 0; c < ARRAY_DIM; c++) begin
        if (KW'(r) < k_q && KW'(c) < k_q) begin
          prod_nxt[r*ARRAY_DIM+c] =
            prod_t'($signed(i_img[(r*ARRAY_DIM+c)*DATA_WIDTH +: DATA_WIDTH])) *
            prod_t'(wgt_active[r][c]);
        end else begin
          prod_nxt[r*ARRAY_DIM+c] = '0;
        end
      end
    end
  end

  // S1: capture products and beat tags on accept, hold while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      for (int i = 0; i < NE; i++) s1_prod[i] <= '0;
    end else if (!stall) begin
      s1_valid <= i_in_valid;
      if (i_in_valid) begin
        s1_first <= i_first;
        s1_last  <= i_last;
        s1_addr  <= i_addr;
        for (int i = 0; i < NE; i++) s1_prod[i] <= prod_nxt[i];
      end
    end
  end

  // S2: reduce, add base, saturate to the accumulator, then round/shift/clip for output.
  always_comb begin
    dot = '0;
    for (int i = 0; i < NE; i++) dot = dot + SUM_W'(s1_prod[i]);
    base    = s1_first ? (SUM_W'(bias_q) <<< shift_q) : SUM_W'(psum[s1_addr]);
    sum_raw = dot + base;
    if (sum_raw > ACC_MAX)      sum_sat = ACC_MAX[ACC_WIDTH-1:0];
    else if (sum_raw < ACC_MIN) sum_sat = ACC_MIN[ACC_WIDTH-1:0];
    else                        sum_sat = sum_raw[ACC_WIDTH-1:0];
    // Half-LSB rounding term; collapses to zero when shift is zero.
    rnd_add = (RND_W'(1) << shift_q) >> 1;
    rnd_sum = RND_W'(sum_sat) + rnd_add;
    shifted = rnd_sum >>> shift_q;
    if (shifted > RES_MAX)      res_nxt = RES_MAX[DATA_WIDTH-1:0];
    else if (shifted < RES_MIN) res_nxt = RES_MIN[DATA_WIDTH-1:0];
    else                        res_nxt = shifted[DATA_WIDTH-1:0];
    if (relu_q && res_nxt[DATA_WIDTH-1]) res_nxt = '0;
  end

  // Partial sums: written only when a non-last beat leaves S2.
  always_ff @(posedge i_clk) begin
    if (!stall && s1_valid && !s1_last) psum[s1_addr] <= sum_sat;
  end

  // Output register: refills in the same cycle the previous result is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid <= 1'b0;
      o_result    <= '0;
    end else if (!stall) begin
      if (s1_valid && s1_last) begin
        o_out_valid <= 1'b1;
        o_result    <= res_nxt;
      end else begin
        o_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_acc_pipe.sv
// Bench for pe_acc_pipe: table of single-beat vectors, hand sequences for
// accumulation, stall, weight swap and reset, and a randomized run checked
// against an arithmetic reference model.
module tb_pe_acc_pipe;
  localparam int DW = 8;
  localparam int N  = 6;
  localparam int AC = 24;
  localparam int PD = 16;
  localparam int SW = 4;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_cfg_wr;
  logic [2:0]            i_ksize;
  logic [SW-1:0]         i_shift;
  logic                  i_relu;
  logic [DW-1:0]         i_bias;
  logic                  i_wgt_wr_en;
  logic [2:0]            i_wgt_row;
  logic [N*DW-1:0]       i_wgt_data;
  logic                  i_wgt_swap;
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [N*N*DW-1:0]     i_img;
  logic                  i_first;
  logic                  i_last;
  logic [3:0]            i_addr;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [DW-1:0]         o_result;
  logic                  o_busy;

  pe_acc_pipe #(.DATA_WIDTH(DW), .ARRAY_DIM(N), .ACC_WIDTH(AC), .PSUM_DEPTH(PD), .SHIFT_WIDTH(SW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_wr(i_cfg_wr), .i_ksize(i_ksize), .i_shift(i_shift),
    .i_relu(i_relu), .i_bias(i_bias), .i_wgt_wr_en(i_wgt_wr_en), .i_wgt_row(i_wgt_row),
    .i_wgt_data(i_wgt_data), .i_wgt_swap(i_wgt_swap), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_img(i_img), .i_first(i_first), .i_last(i_last), .i_addr(i_addr), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_result(o_result), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      exp_q[$];
  int      obs_q[$];
  int      wsh [N][N];
  int      wac [N][N];
  int      m_k, m_shift, m_relu, m_bias;
  longint  psum_m [PD];
  bit      last_acc;
  bit      tb_cfg_locked;

  typedef struct {
    int k; int sh; int relu; int bias; int w; int img; int exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [N*N*DW-1:0] img_fill(input int v);
    logic [DW-1:0] b;
    b = DW'(v);
    return {(N*N){b}};
  endfunction

  function automatic void model_reset();
    m_k = N; m_shift = 0; m_relu = 0; m_bias = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin wsh[r][c] = 0; wac[r][c] = 0; end
    exp_q.delete();
  endfunction

  // Reference: dot product over the KxK corner, base, accumulator clip, round/shift/clip.
  function automatic void model_beat();
    longint dot, base, s, r;
    dot = 0;
    for (int rr = 0; rr < N; rr++)
      for (int cc = 0; cc < N; cc++)
        if (rr < m_k && cc < m_k)
          dot += longint'($signed(i_img[(rr*N+cc)*DW +: DW])) * longint'(wac[rr][cc]);
    if (i_first) base = longint'(m_bias) * (longint'(1) << m_shift);
    else         base = psum_m[i_addr];
    s = clamp(dot + base, -(longint'(1) << (AC-1)), (longint'(1) << (AC-1)) - 1);
    if (!i_last) psum_m[i_addr] = s;
    else begin
      r = s + ((m_shift > 0) ? (longint'(1) << (m_shift-1)) : longint'(0));
      r = r >>> m_shift;
      r = clamp(r, -128, 127);
      if (m_relu != 0 && r < 0) r = 0;
      exp_q.push_back(int'(r));
    end
  endfunction

  // One clock: sample just before the rising edge, update the model, return at the falling edge.
  task automatic step();
    #4;
    last_acc = i_in_valid && o_in_ready;
    if (o_out_valid && i_out_ready) begin
      obs_q.push_back(int'($signed(o_result)));
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out_unexpected: got result %0d, expected no output", $signed(o_result));
      end else begin
        check("model_result", longint'($signed(o_result)), longint'(exp_q.pop_front()));
      end
    end
    if (i_cfg_wr && !tb_cfg_locked) begin
      m_k     = (int'(i_ksize) == 0 || int'(i_ksize) > N) ? N : int'(i_ksize);
      m_shift = int'(i_shift);
      m_relu  = int'(i_relu);
      m_bias  = int'($signed(i_bias));
    end
    if (last_acc) model_beat();
    if (i_wgt_swap) wac = wsh;
    if (i_wgt_wr_en && int'(i_wgt_row) < N)
      for (int c = 0; c < N; c++) wsh[i_wgt_row][c] = int'($signed(i_wgt_data[c*DW +: DW]));
    @(negedge i_clk);
  endtask

  task automatic set_cfg(input int k, input int sh, input int relu, input int bias);
    i_cfg_wr = 1'b1; i_ksize = 3'(k); i_shift = SW'(sh); i_relu = 1'(relu); i_bias = DW'(bias);
    step();
    i_cfg_wr = 1'b0;
  endtask

  task automatic wr_row(input int row, input logic [N*DW-1:0] data);
    i_wgt_wr_en = 1'b1; i_wgt_row = 3'(row); i_wgt_data = data;
    step();
    i_wgt_wr_en = 1'b0;
  endtask

  task automatic load_uniform(input int v);
    logic [DW-1:0] b;
    b = DW'(v);
    for (int r = 0; r < N; r++) wr_row(r, {N{b}});
    i_wgt_swap = 1'b1;
    step();
    i_wgt_swap = 1'b0;
  endtask

  task automatic send_beat(input logic [N*N*DW-1:0] img, input bit first, input bit last, input int addr);
    int i;
    i_img = img; i_first = first; i_last = last; i_addr = 4'(addr); i_in_valid = 1'b1;
    for (i = 0; i < 60; i++) begin
      step();
      if (last_acc) break;
    end
    i_in_valid = 1'b0;
    n_tests++;
    if (i == 60) begin
      n_fail++;
      $display("FAIL accept_timeout: beat not accepted within 60 cycles, expected acceptance");
    end
  endtask

  task automatic drain(input string tag);
    int i;
    i_in_valid = 1'b0; i_out_ready = 1'b1;
    for (i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !o_busy && !o_out_valid) break;
      step();
    end
    n_tests++;
    if (i == 60) begin
      n_fail++;
      $display("FAIL drain_%s: still busy after 60 cycles with %0d results pending, expected empty", tag, exp_q.size());
    end
  endtask

  task automatic check_obs(input string name, input int exp[$]);
    check({name, "_count"}, obs_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
      check(name, obs_q[i], exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_l[$];
    bit open [4];
    logic [N*N*DW-1:0] rimg;

    vecs[0] = '{k:3, sh:0, relu:0, bias:0,  w:1,   img:2,    exp:18};
    vecs[1] = '{k:6, sh:0, relu:0, bias:0,  w:127, img:127,  exp:127};
    vecs[2] = '{k:6, sh:0, relu:0, bias:0,  w:127, img:-127, exp:-128};
    vecs[3] = '{k:6, sh:0, relu:1, bias:0,  w:127, img:-127, exp:0};
    vecs[4] = '{k:1, sh:2, relu:0, bias:1,  w:5,   img:1,    exp:2};
    vecs[5] = '{k:0, sh:0, relu:0, bias:0,  w:1,   img:1,    exp:36};
    vecs[6] = '{k:7, sh:0, relu:0, bias:0,  w:1,   img:1,    exp:36};
    vecs[7] = '{k:2, sh:1, relu:0, bias:-2, w:-3,  img:5,    exp:-32};
    vecs[8] = '{k:4, sh:3, relu:1, bias:0,  w:2,   img:-1,   exp:0};
    vecs[9] = '{k:5, sh:4, relu:0, bias:3,  w:10,  img:10,   exp:127};

    i_rst_n = 1'b0; i_cfg_wr = 0; i_ksize = 0; i_shift = 0; i_relu = 0; i_bias = 0;
    i_wgt_wr_en = 0; i_wgt_row = 0; i_wgt_data = '0; i_wgt_swap = 0; i_in_valid = 0;
    i_img = '0; i_first = 0; i_last = 0; i_addr = 0; i_out_ready = 1; tb_cfg_locked = 0;
    for (int a = 0; a < PD; a++) psum_m[a] = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_busy", o_busy, 0);
    check("rst_in_ready", o_in_ready, 1);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single-beat table with latency check
    foreach (vecs[v]) begin
      set_cfg(vecs[v].k, vecs[v].sh, vecs[v].relu, vecs[v].bias);
      load_uniform(vecs[v].w);
      send_beat(img_fill(vecs[v].img), 1, 1, v);
      check("lat_t1_valid", o_out_valid, 0);
      step();
      check("lat_t2_valid", o_out_valid, 1);
      check("vec_result", longint'($signed(o_result)), vecs[v].exp);
      drain("vec");
    end

    // Multi-channel accumulation, then interleaved pixels
    set_cfg(3, 0, 0, 0);
    load_uniform(1);
    obs_q.delete();
    for (int b = 0; b < 4; b++) send_beat(img_fill(1), b == 0, b == 3, 5);
    drain("acc");
    exp_l = '{36};
    check_obs("acc4", exp_l);
    obs_q.delete();
    for (int b = 0; b < 8; b++) send_beat(img_fill((b % 2 == 1) ? 2 : 1), b < 2, b >= 6, (b % 2 == 1) ? 6 : 5);
    drain("interleave");
    exp_l = '{36, 72};
    check_obs("interleave", exp_l);

    // Backpressure: results held, input refused, config write ignored while busy
    obs_q.delete();
    i_out_ready = 1'b0;
    send_beat(img_fill(1), 1, 1, 0);
    send_beat(img_fill(2), 1, 1, 1);
    i_img = img_fill(3); i_first = 1; i_last = 1; i_addr = 2; i_in_valid = 1'b1;
    tb_cfg_locked = 1'b1;
    i_cfg_wr = 1'b1; i_ksize = 3'd1;
    for (int s = 0; s < 4; s++) begin
      step();
      i_cfg_wr = 1'b0;
      check("stall_in_ready", o_in_ready, 0);
      check("stall_valid", o_out_valid, 1);
      check("stall_result", longint'($signed(o_result)), 9);
    end
    tb_cfg_locked = 1'b0;
    i_out_ready = 1'b1;
    send_beat(img_fill(3), 1, 1, 2);
    drain("stall");
    exp_l = '{9, 18, 27};
    check_obs("stall_order", exp_l);

    // Weight swap ordering
    set_cfg(1, 0, 0, 0);
    load_uniform(1);
    for (int r = 0; r < N; r++) wr_row(r, {N{8'd2}});
    obs_q.delete();
    send_beat(img_fill(3), 1, 1, 0);
    i_wgt_swap = 1'b1; step(); i_wgt_swap = 1'b0;
    send_beat(img_fill(3), 1, 1, 0);
    i_wgt_wr_en = 1'b1; i_wgt_row = 0; i_wgt_data = {N{8'd5}}; i_wgt_swap = 1'b1;
    step();
    i_wgt_wr_en = 1'b0; i_wgt_swap = 1'b0;
    send_beat(img_fill(3), 1, 1, 0);
    i_wgt_swap = 1'b1; step(); i_wgt_swap = 1'b0;
    send_beat(img_fill(3), 1, 1, 0);
    wr_row(0, {N{8'd7}});
    i_wgt_swap = 1'b1;
    send_beat(img_fill(3), 1, 1, 0);
    i_wgt_swap = 1'b0;
    send_beat(img_fill(3), 1, 1, 0);
    drain("swap");
    exp_l = '{3, 6, 6, 15, 15, 21};
    check_obs("swap_seq", exp_l);

    // Randomized traffic against the model
    for (int bt = 0; bt < 4; bt++) begin
      drain("rand_pre");
      set_cfg($urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 1), $urandom_range(0, 255));
      for (int r = 0; r < N; r++) wr_row(r, (N*DW)'({$urandom(), $urandom()}));
      i_wgt_swap = 1'b1; step(); i_wgt_swap = 1'b0;
      for (int a = 0; a < 4; a++) open[a] = 1'b0;
      for (int cy = 0; cy < 80; cy++) begin
        int a;
        i_out_ready = ($urandom_range(0, 3) != 0);
        i_in_valid  = ($urandom_range(0, 3) != 0);
        a = $urandom_range(0, 3);
        i_addr  = 4'(a);
        i_first = !open[a];
        i_last  = ($urandom_range(0, 2) == 0);
        for (int e = 0; e < N*N; e++) rimg[e*DW +: DW] = DW'($urandom());
        i_img = rimg;
        i_wgt_wr_en = ($urandom_range(0, 9) == 0);
        i_wgt_row   = 3'($urandom_range(0, 7));
        i_wgt_data  = (N*DW)'({$urandom(), $urandom()});
        i_wgt_swap  = ($urandom_range(0, 14) == 0);
        step();
        if (last_acc) open[a] = !i_last;
      end
      i_wgt_wr_en = 1'b0; i_wgt_swap = 1'b0;
      for (int a = 0; a < 4; a++) begin
        if (open[a]) send_beat(img_fill(1), 0, 1, a);
      end
      drain("rand");
    end

    // Reset mid-stream discards everything in flight
    set_cfg(2, 0, 0, 0);
    load_uniform(1);
    i_out_ready = 1'b0;
    send_beat(img_fill(1), 1, 1, 0);
    send_beat(img_fill(1), 1, 0, 3);
    step();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", o_out_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_in_ready", o_in_ready, 1);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_out_ready = 1'b1;
    obs_q.delete();
    repeat (5) step();
    check("postrst_no_output", obs_q.size(), 0);
    check("postrst_valid", o_out_valid, 0);
    send_beat(img_fill(9), 1, 1, 0);
    drain("postrst");
    exp_l = '{0};
    check_obs("postrst_zero_wgt", exp_l);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_acc_pipe.md
Name: pe_acc_pipe

Overview:
Parametrised second-generation convolution PE. Computes a signed dot product of an ARRAY_DIM x ARRAY_DIM image window against a kernel of size K (K <= ARRAY_DIM) held in a double-buffered weight register file. Accumulates the result across input-channel beats in an internal psum buffer. On the last channel it applies rounding shift, saturation and optional ReLU, then presents an 8-bit result behind a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, signed element width for image, weight, bias and result
ARRAY_DIM, 6, window and weight-file dimension (square)
ACC_WIDTH, 24, signed accumulator and psum-buffer entry width
PSUM_DEPTH, 16, number of psum-buffer entries (outstanding output pixels)
SHIFT_WIDTH, 4, width of the output right-shift amount

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cfg_wr  in  1  load i_ksize, i_shift, i_relu and i_bias; ignored while o_busy=1
i_ksize  in  clog2(ARRAY_DIM+1)  kernel size K; 0 or >ARRAY_DIM is treated as ARRAY_DIM
i_shift  in  SHIFT_WIDTH  output arithmetic right shift
i_relu  in  1  enable ReLU on the output
i_bias  in  DATA_WIDTH  signed bias
i_wgt_wr_en  in  1  write one row of the shadow weight bank
i_wgt_row  in  clog2(ARRAY_DIM)  row index; out-of-range writes are ignored
i_wgt_data  in  ARRAY_DIM*DATA_WIDTH  row data, column c at bits [(c+1)*DW-1 -: DW]
i_wgt_swap  in  1  copy shadow bank to active bank
i_in_valid  in  1  input beat valid
o_in_ready  out  1  input beat accepted when valid and ready are both 1
i_img  in  ARRAY_DIM*ARRAY_DIM*DATA_WIDTH  window; element (r,c) at bits [(r*ARRAY_DIM+c+1)*DW-1 -: DW]
i_first  in  1  first channel of the pixel (base is the bias)
i_last  in  1  last channel of the pixel (produces output)
i_addr  in  clog2(PSUM_DEPTH)  psum-buffer entry for this pixel
o_out_valid  out  1  result valid
i_out_ready  in  1  result consumed
o_result  out  DATA_WIDTH  signed result
o_busy  out  1  an S1 or S2 stage or the output register is occupied

Behaviour:
- Reset (asynchronous, active-low) values:
  - o_out_valid=0, o_result=0, o_busy=0, o_in_ready=1.
  - Both weight banks zero.
  - Config: K=ARRAY_DIM, shift=0, relu=0, bias=0.
  - Stage valids 0.
  - psum buffer contents are not reset (undefined); a pixel must start with i_first.
  - Reset mid-operation discards all in-flight beats and any pending output.
- Stall:
  - stall = o_out_valid & ~i_out_ready.
  - o_in_ready = ~stall (combinational).
  - While stalled, S1 and S2 hold their contents.
- S1 (registered on accept):
  - Registers products p(r,c) = img(r,c)*w_active(r,c), each signed 2*DATA_WIDTH.
  - p(r,c) is forced to 0 when r>=K or c>=K.
  - first, last and addr are carried with the products.
  - Weights are sampled at accept time, so an i_wgt_swap in the same or a later cycle does not affect a beat already in S1.
- S2 (registered one cycle after S1):
  - sum = sign-extended sum of all products + base.
  - base = first ? (bias <<< shift) : psum[addr].
  - sum saturates to the signed ACC_WIDTH range.
  - If not last: psum[addr] <= sum.
  - If last: the psum buffer is not written and the output register is loaded.
  - psum[addr] is read in the same cycle as S2 evaluation, so back-to-back beats to the same address accumulate correctly with no bubble.
- Output:
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift.
  - r saturates to [-2^(DW-1), 2^(DW-1)-1]; if relu=1, a negative r becomes 0.
  - o_out_valid stays high with o_result stable until i_out_ready=1.
  - A new last beat may load the output register in the same cycle the previous result is consumed.
- Latency:
  - A last beat accepted in cycle t gives o_out_valid=1 in cycle t+2 when there is no stall.
  - Sustained throughput is 1 beat/cycle.
- Weights:
  - Shadow write takes effect next cycle.
  - Write and swap in the same cycle: active receives the pre-write shadow; the write lands in shadow.
- i_first and i_last together: single-channel pixel, bias base, output produced.

Test Plan:
- Reset, then load all weights=1, K=3, shift=0, bias=0. One beat, first=last=1, image all 2 -> o_result=18, and o_out_valid rises 2 cycles after accept.
- Same config, 4 beats to addr=5 with image all 1; first on beat 0, last on beat 3 -> o_result=36. Repeat interleaving addr 5 and 6 on alternate cycles -> two results of 36 in issue order.
- K=6, weights=127, image=127, shift=0 -> o_result=127 (saturation). Negate the image -> -128; set relu=1 -> 0.
- shift=2, bias=1, one beat with dot product=5 -> (5+4+2)>>2 = 2.
- Hold i_out_ready=0 with two last beats in flight -> o_in_ready=0, o_result stays stable; release -> both results appear in order, none lost or duplicated.
- Write shadow rows with 2 while active weights are 1; issue a beat, then i_wgt_swap, then another beat (K=1, image=3) -> results 3 then 6. Assert i_rst_n=0 mid-stream -> o_out_valid=0 immediately, no stale result after release.
